// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and serializer-side signal bundle for the UART TX arbiter.
interface uart_tx_arbiter_if #(
  parameter int unsigned P_REQ_NUM         = 4,
  parameter int unsigned P_UART_DATA_WIDTH = 8
);

  logic [P_REQ_NUM-1:0]                   i_req_valid;
  logic [P_REQ_NUM*P_UART_DATA_WIDTH-1:0] i_req_data;
  logic [P_REQ_NUM-1:0]                   i_req_last;
  logic [P_REQ_NUM-1:0]                   o_req_ready;
  logic                                   o_tx_valid;
  logic [P_UART_DATA_WIDTH-1:0]           o_tx_data;
  logic                                   i_tx_ready;
  logic [P_REQ_NUM-1:0]                   o_grant;
  logic                                   o_busy;
  logic                                   o_timeout;

  // Arbiter side
  modport master (
    input  i_req_valid, i_req_data, i_req_last, i_tx_ready,
    output o_req_ready, o_tx_valid, o_tx_data, o_grant, o_busy, o_timeout
  );

  // Requesters plus serializer side
  modport slave (
    output i_req_valid, i_req_data, i_req_last, i_tx_ready,
    input  o_req_ready, o_tx_valid, o_tx_data, o_grant, o_busy, o_timeout
  );

endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-locked arbiter sharing one uart_tx between N byte-stream
// requesters. A one-entry holding register breaks the requester-to-UART path.
module uart_tx_arbiter #(
  parameter int unsigned P_REQ_NUM         = 4,
  parameter int unsigned P_UART_DATA_WIDTH = 8,
  parameter int unsigned P_LOCK_TIMEOUT    = 1000
) (
  input logic               i_clk,
  input logic               i_rst,
  uart_tx_arbiter_if.master bus
);

  localparam int unsigned N     = P_REQ_NUM;
  localparam int unsigned W     = P_UART_DATA_WIDTH;
  localparam int unsigned PTR_W = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CNT_W = 16;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] TIMEOUT  = CNT_W'(P_LOCK_TIMEOUT);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(N - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEND} state_t;

  state_t           state, state_nxt;
  logic [PTR_W-1:0] ptr, ptr_nxt;
  logic [PTR_W-1:0] gidx, gidx_nxt;
  logic [N-1:0]     grant, grant_nxt;
  logic [N-1:0]     ready, ready_nxt;
  logic [CNT_W-1:0] stall, stall_nxt;
  logic [W-1:0]     data, data_nxt;
  logic             last, last_nxt;
  logic             tx_valid, tx_valid_nxt;
  logic             busy, busy_nxt;
  logic             timeout, timeout_nxt;

  logic             found;
  logic [PTR_W-1:0] win;
  int unsigned      cand;
  logic             sel_valid;
  logic             sel_last;
  logic [W-1:0]     sel_data;
  logic [PTR_W-1:0] next_ptr;
  logic [CNT_W-1:0] stall_inc;

  // First valid requester searching upward from ptr, wrapping at N
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = 0;
    for (int unsigned i = 0; i < N; i++) begin
      cand = 32'(ptr) + i;
      if (cand >= N) cand = cand - N;
      if (!found && bus.i_req_valid[PTR_W'(cand)]) begin
        found = 1'b1;
        win   = PTR_W'(cand);
      end
    end
  end

  // Granted requester's port, selected by the one-hot grant
  always_comb begin
    sel_valid = |(bus.i_req_valid & grant);
    sel_last  = |(bus.i_req_last & grant);
    sel_data  = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (grant[k]) sel_data = sel_data | bus.i_req_data[k*W +: W];
    end
  end

  // Helpers: pointer past the current owner, saturating stall increment
  always_comb begin
    next_ptr  = (gidx == LAST_IDX) ? '0 : gidx + PTR_W'(1);
    stall_inc = (stall == CNT_MAX) ? stall : stall + CNT_W'(1);
  end

  // Next-state and registered-output decode
  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    gidx_nxt    = gidx;
    grant_nxt   = grant;
    stall_nxt   = stall;
    data_nxt    = data;
    last_nxt    = last;
    timeout_nxt = 1'b0;

    case (state)
      S_IDLE: begin
        if (found) begin
          gidx_nxt  = win;
          grant_nxt = N'(1) << win;
          stall_nxt = '0;
          state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        if (sel_valid) begin
          data_nxt  = sel_data;
          last_nxt  = sel_last;
          state_nxt = S_SEND;
        end else begin
          stall_nxt = stall_inc;
          if ((P_LOCK_TIMEOUT != 0) && (stall_inc >= TIMEOUT)) begin
            timeout_nxt = 1'b1;
            ptr_nxt     = next_ptr;
            grant_nxt   = '0;
            state_nxt   = S_IDLE;
          end
        end
      end
      S_SEND: begin
        if (tx_valid && bus.i_tx_ready) begin
          if (last) begin
            ptr_nxt   = next_ptr;
            grant_nxt = '0;
            state_nxt = S_IDLE;
          end else begin
            stall_nxt = '0;
            state_nxt = S_LOAD;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    // Outputs follow the next state so they line up with it after the edge
    ready_nxt    = (state_nxt == S_LOAD) ? grant_nxt : '0;
    tx_valid_nxt = (state_nxt == S_SEND);
    busy_nxt     = (state_nxt != S_IDLE);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= S_IDLE;
      ptr      <= '0;
      gidx     <= '0;
      grant    <= '0;
      ready    <= '0;
      stall    <= '0;
      data     <= '0;
      last     <= 1'b0;
      tx_valid <= 1'b0;
      busy     <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      gidx     <= gidx_nxt;
      grant    <= grant_nxt;
      ready    <= ready_nxt;
      stall    <= stall_nxt;
      data     <= data_nxt;
      last     <= last_nxt;
      tx_valid <= tx_valid_nxt;
      busy     <= busy_nxt;
      timeout  <= timeout_nxt;
    end
  end

  assign bus.o_req_ready = ready;
  assign bus.o_tx_valid  = tx_valid;
  assign bus.o_tx_data   = data;
  assign bus.o_grant     = grant;
  assign bus.o_busy      = busy;
  assign bus.o_timeout   = timeout;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: arbitration vector table, hand-written
// timeout/reset/lock sequences, and randomized message streams against a
// message-level round-robin reference.
module tb_uart_tx_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned W  = 8;
  localparam int unsigned TO = 8;
  localparam int unsigned DEPTH = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;

  uart_tx_arbiter_if #(.P_REQ_NUM(N), .P_UART_DATA_WIDTH(W)) bus ();

  uart_tx_arbiter #(
    .P_REQ_NUM(N),
    .P_UART_DATA_WIDTH(W),
    .P_LOCK_TIMEOUT(TO)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_req(input int k, input logic v, input logic [7:0] d, input logic l);
    bus.i_req_valid[k]      = v;
    bus.i_req_data[k*W +: W] = d;
    bus.i_req_last[k]       = l;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.i_req_valid = '0;
    bus.i_req_data  = '0;
    bus.i_req_last  = '0;
    bus.i_tx_ready  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Arbitration vectors: requester k drives base+k, single-byte messages
  typedef struct {
    logic [N-1:0] valid;
    logic [7:0]   base;
    logic [N-1:0] exp_grant;
    logic [7:0]   exp_data;
  } vec_t;

  vec_t vt[8];

  // Requester byte streams ({last, data}) and expected UART stream
  logic [8:0] rmem [N][DEPTH];
  int         rhead[N];
  int         rtail[N];
  int         exp_own[$];
  logic [7:0] exp_byte[$];

  task automatic clear_streams();
    for (int k = 0; k < int'(N); k++) begin
      rhead[k] = 0;
      rtail[k] = 0;
    end
    exp_own.delete();
    exp_byte.delete();
  endtask

  task automatic push_byte(input int k, input logic [7:0] d, input logic l);
    rmem[k][rtail[k]] = {l, d};
    rtail[k]++;
    exp_own.push_back(k);
    exp_byte.push_back(d);
  endtask

  // Drive all streams until the expected UART stream is consumed
  task automatic run_stream(input int budget, input bit rand_ready);
    int cyc;
    int own;
    logic [7:0] eb;
    cyc = 0;
    while (exp_byte.size() != 0 && cyc < budget) begin
      for (int k = 0; k < int'(N); k++) begin
        if (rhead[k] < rtail[k])
          set_req(k, 1'b1, rmem[k][rhead[k]][7:0], rmem[k][rhead[k]][8]);
        else
          set_req(k, 1'b0, 8'h00, 1'b0);
      end
      bus.i_tx_ready = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
      chk("ready_onehot", 32'($countones(bus.o_req_ready) <= 1), 32'(1));
      for (int k = 0; k < int'(N); k++) begin
        if (bus.i_req_valid[k] && bus.o_req_ready[k]) rhead[k]++;
      end
      if (bus.o_tx_valid && bus.i_tx_ready) begin
        own = exp_own.pop_front();
        eb  = exp_byte.pop_front();
        chk("stream_data", 32'(bus.o_tx_data), 32'(eb));
        chk("stream_grant", 32'(bus.o_grant), 32'(1) << own);
      end
      step();
      cyc++;
    end
    chk("stream_done", 32'(exp_byte.size()), 32'(0));
    for (int k = 0; k < int'(N); k++) chk("stream_drained", 32'(rtail[k] - rhead[k]), 32'(0));
    bus.i_req_valid = '0;
    bus.i_tx_ready  = 1'b0;
    step();
  endtask

  initial begin
    int cnt[N];
    int len;
    int maxr;

    bus.i_req_valid = '0;
    bus.i_req_data  = '0;
    bus.i_req_last  = '0;
    bus.i_tx_ready  = 1'b0;

    vt[0] = '{4'b0010, 8'hA4, 4'b0010, 8'hA5};
    vt[1] = '{4'b1111, 8'h10, 4'b0100, 8'h12};
    vt[2] = '{4'b0011, 8'h20, 4'b0001, 8'h20};
    vt[3] = '{4'b1001, 8'h30, 4'b1000, 8'h33};
    vt[4] = '{4'b1000, 8'h40, 4'b1000, 8'h43};
    vt[5] = '{4'b0110, 8'h50, 4'b0010, 8'h51};
    vt[6] = '{4'b0001, 8'h60, 4'b0001, 8'h60};
    vt[7] = '{4'b0101, 8'h70, 4'b0100, 8'h72};

    // Reset values
    do_reset();
    chk("rst_ready", 32'(bus.o_req_ready), 32'(0));
    chk("rst_tx_valid", 32'(bus.o_tx_valid), 32'(0));
    chk("rst_tx_data", 32'(bus.o_tx_data), 32'(0));
    chk("rst_grant", 32'(bus.o_grant), 32'(0));
    chk("rst_busy", 32'(bus.o_busy), 32'(0));
    chk("rst_timeout", 32'(bus.o_timeout), 32'(0));

    // Arbitration table, pointer carried from entry to entry
    bus.i_tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < int'(N); k++)
        set_req(k, vt[i].valid[k], vt[i].base + 8'(k), 1'b1);
      step();
      chk("tbl_grant", 32'(bus.o_grant), 32'(vt[i].exp_grant));
      chk("tbl_ready", 32'(bus.o_req_ready), 32'(vt[i].exp_grant));
      step();
      bus.i_req_valid = '0;
      chk("tbl_tx_valid", 32'(bus.o_tx_valid), 32'(1));
      chk("tbl_tx_data", 32'(bus.o_tx_data), 32'(vt[i].exp_data));
      step();
      chk("tbl_idle_busy", 32'(bus.o_busy), 32'(0));
      chk("tbl_idle_grant", 32'(bus.o_grant), 32'(0));
    end

    // Message lock: req0's three bytes complete before req2's byte
    do_reset();
    clear_streams();
    push_byte(0, 8'h11, 1'b0);
    push_byte(0, 8'h22, 1'b0);
    push_byte(0, 8'h33, 1'b1);
    push_byte(2, 8'h44, 1'b1);
    run_stream(200, 1'b0);

    // Fairness: every requester has two single-byte messages
    do_reset();
    clear_streams();
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < int'(N); k++) push_byte(k, 8'($urandom), 1'b1);
    run_stream(300, 1'b0);

    // Timeout: req3 stalls mid-message, req0 waits
    do_reset();
    bus.i_tx_ready = 1'b1;
    set_req(3, 1'b1, 8'h77, 1'b0);
    step();
    chk("to_grant3", 32'(bus.o_grant), 32'(4'b1000));
    step();
    set_req(3, 1'b0, 8'h00, 1'b0);
    set_req(0, 1'b1, 8'h5C, 1'b1);
    chk("to_tx_valid", 32'(bus.o_tx_valid), 32'(1));
    step();
    for (int j = 0; j < int'(TO); j++) begin
      chk("to_no_pulse", 32'(bus.o_timeout), 32'(0));
      chk("to_locked", 32'(bus.o_req_ready), 32'(4'b1000));
      step();
    end
    chk("to_pulse", 32'(bus.o_timeout), 32'(1));
    chk("to_grant_clear", 32'(bus.o_grant), 32'(0));
    chk("to_busy_clear", 32'(bus.o_busy), 32'(0));
    step();
    chk("to_pulse_end", 32'(bus.o_timeout), 32'(0));
    chk("to_next_grant", 32'(bus.o_grant), 32'(4'b0001));
    step();
    set_req(0, 1'b0, 8'h00, 1'b0);
    chk("to_req0_data", 32'(bus.o_tx_data), 32'(8'h5C));
    step();
    chk("to_req0_done", 32'(bus.o_busy), 32'(0));

    // Reset while a byte is held in S_SEND
    do_reset();
    bus.i_tx_ready = 1'b0;
    set_req(1, 1'b1, 8'h5A, 1'b1);
    step();
    chk("rs_grant", 32'(bus.o_grant), 32'(4'b0010));
    step();
    set_req(1, 1'b0, 8'h00, 1'b0);
    chk("rs_held_valid", 32'(bus.o_tx_valid), 32'(1));
    chk("rs_held_data", 32'(bus.o_tx_data), 32'(8'h5A));
    step();
    chk("rs_still_held", 32'(bus.o_tx_valid), 32'(1));
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rs_ready", 32'(bus.o_req_ready), 32'(0));
    chk("rs_tx_valid", 32'(bus.o_tx_valid), 32'(0));
    chk("rs_tx_data", 32'(bus.o_tx_data), 32'(0));
    chk("rs_grant0", 32'(bus.o_grant), 32'(0));
    chk("rs_busy", 32'(bus.o_busy), 32'(0));
    chk("rs_timeout", 32'(bus.o_timeout), 32'(0));
    bus.i_tx_ready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      step();
      chk("rs_no_send", 32'(bus.o_tx_valid), 32'(0));
    end
    set_req(0, 1'b1, 8'h01, 1'b1);
    set_req(1, 1'b1, 8'h02, 1'b1);
    step();
    chk("rs_rearb", 32'(bus.o_grant), 32'(4'b0001));

    // Randomized message streams with random serializer back-pressure
    for (int it = 0; it < 4; it++) begin
      do_reset();
      clear_streams();
      maxr = 0;
      for (int k = 0; k < int'(N); k++) begin
        cnt[k] = int'($urandom_range(0, 3));
        if (cnt[k] > maxr) maxr = cnt[k];
      end
      for (int r = 0; r < maxr; r++) begin
        for (int k = 0; k < int'(N); k++) begin
          if (r < cnt[k]) begin
            len = int'($urandom_range(1, 3));
            for (int b = 0; b < len; b++) push_byte(k, 8'($urandom), (b == len - 1));
          end
        end
      end
      run_stream(2000, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
